fetch_mem_unit: RTL and testbench

FETCH_MEM_UNIT -- requirements
Module: fetch_mem_unit

---
 rtl/fetch_mem_unit.sv | 194 +++++++++++++++++++
 tb/tb_fetch_mem_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit
// --------------
// Instruction fetch and load/store sequencer that sits between a simple
// datapath and a single-ported memory. It fetches the word at pc into ir,
// waits for the datapath to finish executing it, and then does one of
// three things: fetches the next instruction, performs one load or store,
// or halts.
//
// Optional feature: define FETCH_MEM_TIMEOUT_EN to add a memory wait
// watchdog. When FETCH or MEM has waited TIMEOUT consecutive cycles without
// mem_ready, the unit raises a sticky timeout_err and halts. Without the
// macro, FETCH and MEM wait forever and timeout_err is tied to 0.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   s            start/restart request (only honoured in IDLE and HALT)
//   mem_ready    memory accepted/completed the current command
//   read_data    memory read data, valid with mem_ready
//   exec_done    datapath finished the current instruction
//   exec_op      00 none, 01 load, 10 store, 11 halt (sampled with exec_done)
//   exec_addr    load/store address (sampled with exec_done)
//   exec_wdata   store data (sampled with exec_done)
//   pc_load      branch request (sampled with exec_done)
//   pc_target    branch target (sampled with exec_done)
//   mem_cmd      00 none, 01 read, 10 write
//   mem_addr     memory address
//   write_data   store data while mem_cmd is 10, otherwise 0
//   ir/ir_valid  instruction register and its one-cycle update pulse
//   load_data/load_valid  load result and its one-cycle update pulse
//   pc           program counter
//   w            1 while idle or halted
//   timeout_err  sticky memory wait timeout flag
module fetch_mem_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] read_data,
    input  logic              exec_done,
    input  logic [1:0]        exec_op,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [DATA_W-1:0] exec_wdata,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              w,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM,
        HALT
    } state_t;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    state_t            state;
    logic [1:0]        mem_op;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

`ifdef FETCH_MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Sequencer. Every output below is decoded purely from registered
    // state, so the memory interface never sees a combinational path from
    // the inputs. The valid pulses default low and are raised for exactly
    // the one cycle after the corresponding register update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            ir          <= '0;
            ir_valid    <= 1'b0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            mem_op      <= OP_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef FETCH_MEM_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ir_valid   <= 1'b0;
            load_valid <= 1'b0;
`ifdef FETCH_MEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
            case (state)
                IDLE, HALT: begin
                    // Restart from HALT keeps the current pc.
                    if (s) state <= FETCH;
                end
                FETCH: begin
                    if (mem_ready) begin
                        ir       <= read_data;
                        ir_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(1);
                        state    <= DECODE;
                    end
`ifdef FETCH_MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                DECODE: begin
                    if (exec_done) begin
                        if (pc_load) pc <= pc_target;
                        case (exec_op)
                            OP_NONE: state <= FETCH;
                            OP_HALT: state <= HALT;
                            default: begin
                                mem_op      <= exec_op;
                                mem_addr_q  <= exec_addr;
                                mem_wdata_q <= exec_wdata;
                                state       <= MEM;
                            end
                        endcase
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (mem_op == OP_LOAD) begin
                            load_data  <= read_data;
                            load_valid <= 1'b1;
                        end
                        state <= FETCH;
                    end
`ifdef FETCH_MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side decode: the command only exists in FETCH and MEM, and
    // store data is forced to zero whenever a write is not in progress.
    always_comb begin
        mem_cmd    = 2'b00;
        mem_addr   = pc;
        write_data = '0;
        case (state)
            FETCH: mem_cmd = 2'b01;
            MEM: begin
                mem_addr = mem_addr_q;
                if (mem_op == OP_STORE) begin
                    mem_cmd    = 2'b10;
                    write_data = mem_wdata_q;
                end else begin
                    mem_cmd = 2'b01;
                end
            end
            default: mem_cmd = 2'b00;
        endcase
    end

    assign w = (state == IDLE) || (state == HALT);

endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb_fetch_mem_unit
// -----------------
// Directed bench for fetch_mem_unit with the default parameters. Inputs are
// driven 1 ns after each rising edge and outputs are checked at that same
// point, so every check sees settled registered state. Expected values are
// written by hand from the intended behaviour of the unit.
module tb_fetch_mem_unit;

    logic        clk;
    logic        reset;
    logic        s;
    logic        mem_ready;
    logic [15:0] read_data;
    logic        exec_done;
    logic [1:0]  exec_op;
    logic [8:0]  exec_addr;
    logic [15:0] exec_wdata;
    logic        pc_load;
    logic [8:0]  pc_target;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] ir;
    logic        ir_valid;
    logic [15:0] load_data;
    logic        load_valid;
    logic [8:0]  pc;
    logic        w;
    logic        timeout_err;

    int compare_count;
    int mismatch_count;

    fetch_mem_unit dut (
        .clk        (clk),
        .reset      (reset),
        .s          (s),
        .mem_ready  (mem_ready),
        .read_data  (read_data),
        .exec_done  (exec_done),
        .exec_op    (exec_op),
        .exec_addr  (exec_addr),
        .exec_wdata (exec_wdata),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .load_data  (load_data),
        .load_valid (load_valid),
        .pc         (pc),
        .w          (w),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one DECODE completion for the next edge, then clear it.
    task automatic applyStimulus(input logic [1:0] op, input logic [8:0] addr,
                                 input logic [15:0] wdata, input logic load,
                                 input logic [8:0] target);
        exec_done  = 1'b1;
        exec_op    = op;
        exec_addr  = addr;
        exec_wdata = wdata;
        pc_load    = load;
        pc_target  = target;
        tick();
        exec_done  = 1'b0;
        exec_op    = 2'b00;
        pc_load    = 1'b0;
    endtask

    // State of the interface after a reset.
    task automatic checkReset(input string tag);
        checkOutput({tag, "_w"}, 32'(w), 32'h1);
        checkOutput({tag, "_cmd"}, 32'(mem_cmd), 32'h0);
        checkOutput({tag, "_pc"}, 32'(pc), 32'h0);
        checkOutput({tag, "_ir"}, 32'(ir), 32'h0);
        checkOutput({tag, "_ldata"}, 32'(load_data), 32'h0);
        checkOutput({tag, "_irv"}, 32'(ir_valid), 32'h0);
        checkOutput({tag, "_ldv"}, 32'(load_valid), 32'h0);
        checkOutput({tag, "_terr"}, 32'(timeout_err), 32'h0);
        checkOutput({tag, "_wdata"}, 32'(write_data), 32'h0);
    endtask

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        reset      = 1'b0;
        s          = 1'b0;
        mem_ready  = 1'b0;
        read_data  = '0;
        exec_done  = 1'b0;
        exec_op    = 2'b00;
        exec_addr  = '0;
        exec_wdata = '0;
        pc_load    = 1'b0;
        pc_target  = '0;

        #12;
        checkReset("rst");
        tick();
        reset = 1'b1;
        tick();
        checkOutput("idle_w", 32'(w), 32'h1);

        // Basic fetch of 16'h1234 from address 0, then next fetch at 1.
        s = 1'b1;
        tick();
        s = 1'b0;
        checkOutput("f0_cmd", 32'(mem_cmd), 32'h1);
        checkOutput("f0_addr", 32'(mem_addr), 32'h0);
        checkOutput("f0_w", 32'(w), 32'h0);
        mem_ready = 1'b1;
        read_data = 16'h1234;
        tick();
        mem_ready = 1'b0;
        checkOutput("d0_ir", 32'(ir), 32'h1234);
        checkOutput("d0_irv", 32'(ir_valid), 32'h1);
        checkOutput("d0_pc", 32'(pc), 32'h1);
        checkOutput("d0_cmd", 32'(mem_cmd), 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("d0_irv_drop", 32'(ir_valid), 32'h0);
        checkOutput("d0_hold_cmd", 32'(mem_cmd), 32'h0);
        checkOutput("d0_hold_pc", 32'(pc), 32'h1);
        applyStimulus(2'b00, 9'h0, 16'h0, 1'b0, 9'h0);
        checkOutput("f1_cmd", 32'(mem_cmd), 32'h1);
        checkOutput("f1_addr", 32'(mem_addr), 32'h1);

        // s is ignored while fetching.
        s = 1'b1;
        tick();
        s = 1'b0;
        checkOutput("f1_s_ign", 32'(mem_addr), 32'h1);
        checkOutput("f1_s_cmd", 32'(mem_cmd), 32'h1);

        // Branch to 5, then load from 9'h1A0.
        mem_ready = 1'b1;
        read_data = 16'h0042;
        tick();
        mem_ready = 1'b0;
        applyStimulus(2'b00, 9'h0, 16'h0, 1'b1, 9'h005);
        checkOutput("f5_addr", 32'(mem_addr), 32'h5);
        mem_ready = 1'b1;
        read_data = 16'h7001;
        tick();
        mem_ready = 1'b0;
        checkOutput("d5_pc", 32'(pc), 32'h6);
        applyStimulus(2'b01, 9'h1A0, 16'h1111, 1'b0, 9'h0);
        checkOutput("ld_cmd", 32'(mem_cmd), 32'h1);
        checkOutput("ld_addr", 32'(mem_addr), 32'h1A0);
        checkOutput("ld_wdata", 32'(write_data), 32'h0);
        mem_ready = 1'b1;
        read_data = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        checkOutput("ld_data", 32'(load_data), 32'hBEEF);
        checkOutput("ld_valid", 32'(load_valid), 32'h1);
        checkOutput("ld_next_addr", 32'(mem_addr), 32'h6);
        checkOutput("ld_next_cmd", 32'(mem_cmd), 32'h1);
        tick();
        checkOutput("ld_valid_drop", 32'(load_valid), 32'h0);
        checkOutput("ld_data_keep", 32'(load_data), 32'hBEEF);

        // Store with three stalled cycles; command held stable throughout.
        mem_ready = 1'b1;
        read_data = 16'h7002;
        tick();
        mem_ready = 1'b0;
        applyStimulus(2'b10, 9'h0FF, 16'hA5A5, 1'b0, 9'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("st_cmd%0d", i), 32'(mem_cmd), 32'h2);
            checkOutput($sformatf("st_addr%0d", i), 32'(mem_addr), 32'h0FF);
            checkOutput($sformatf("st_wdata%0d", i), 32'(write_data), 32'hA5A5);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        checkOutput("st_after_wdata", 32'(write_data), 32'h0);
        checkOutput("st_after_cmd", 32'(mem_cmd), 32'h1);
        checkOutput("st_after_addr", 32'(mem_addr), 32'h7);
        checkOutput("st_no_ldv", 32'(load_valid), 32'h0);

        // pc wraps from 9'h1FF to 0; a bare pc_load is ignored.
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        applyStimulus(2'b00, 9'h0, 16'h0, 1'b1, 9'h1FF);
        checkOutput("wrap_faddr", 32'(mem_addr), 32'h1FF);
        mem_ready = 1'b1;
        read_data = 16'h0003;
        tick();
        mem_ready = 1'b0;
        checkOutput("wrap_pc", 32'(pc), 32'h0);
        pc_load   = 1'b1;
        pc_target = 9'h123;
        tick();
        pc_load = 1'b0;
        checkOutput("bare_pcload", 32'(pc), 32'h0);
        applyStimulus(2'b00, 9'h0, 16'h0, 1'b1, 9'h040);
        checkOutput("br_addr", 32'(mem_addr), 32'h040);
        checkOutput("br_cmd", 32'(mem_cmd), 32'h1);

        // Halt, restart at the current pc, then reset mid-fetch.
        mem_ready = 1'b1;
        read_data = 16'hC0DE;
        tick();
        mem_ready = 1'b0;
        applyStimulus(2'b11, 9'h0, 16'h0, 1'b0, 9'h0);
        checkOutput("halt_w", 32'(w), 32'h1);
        checkOutput("halt_cmd", 32'(mem_cmd), 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("halt_stay", 32'(w), 32'h1);
        checkOutput("halt_pc", 32'(pc), 32'h041);
        s = 1'b1;
        tick();
        s = 1'b0;
        checkOutput("resume_cmd", 32'(mem_cmd), 32'h1);
        checkOutput("resume_addr", 32'(mem_addr), 32'h041);
        checkOutput("resume_w", 32'(w), 32'h0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        checkReset("async_rst");
        tick();
        reset = 1'b1;
        tick();

        // Memory never answers a fetch.
        s = 1'b1;
        tick();
        s = 1'b0;
`ifdef FETCH_MEM_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        checkOutput("to_pre_cmd", 32'(mem_cmd), 32'h1);
        checkOutput("to_pre_err", 32'(timeout_err), 32'h0);
        tick();
        checkOutput("to_err", 32'(timeout_err), 32'h1);
        checkOutput("to_w", 32'(w), 32'h1);
        checkOutput("to_cmd", 32'(mem_cmd), 32'h0);
`else
        for (int i = 0; i < 20; i++) tick();
        checkOutput("nto_cmd", 32'(mem_cmd), 32'h1);
        checkOutput("nto_w", 32'(w), 32'h0);
        checkOutput("nto_err", 32'(timeout_err), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
